// File: rtl/change_dispenser_controller_pkg.sv
// Shared types and constants for the change dispenser: state encoding, money width and coin denominations.
// The 5-euro coin is only used when DENOM_FIVE_EN is defined; see coin_selector.
package change_dispenser_controller_pkg;

  localparam int MONEY_W = 5;
  localparam int COUNT_W = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CALC     = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [MONEY_W-1:0] DENOM_10 = 5'd10;
  localparam logic [MONEY_W-1:0] DENOM_5  = 5'd5;
  localparam logic [MONEY_W-1:0] DENOM_2  = 5'd2;
  localparam logic [MONEY_W-1:0] DENOM_1  = 5'd1;

  // An underpaid purchase is treated as invalid and refunded in full, so the result never wraps.
  function automatic logic [MONEY_W-1:0] payout_amount(
    input logic [MONEY_W-1:0] money,
    input logic [MONEY_W-1:0] price,
    input logic               refund_all
  );
    if (refund_all || (money < price)) begin
      return money;
    end
    return money - price;
  endfunction

endpackage

// File: rtl/change_dispenser_controller_coin_selector.sv
// Combinational map from the amount still owed to the largest coin not exceeding it.
// DENOM_FIVE_EN adds the 5-euro coin to the set {10,2,1}.
module coin_selector
  import change_dispenser_controller_pkg::*;
(
  input  logic [MONEY_W-1:0] remaining_i,
  output logic [MONEY_W-1:0] coin_o
);

  always_comb begin
    coin_o = '0;
    if (remaining_i >= DENOM_10) begin
      coin_o = DENOM_10;
`ifdef DENOM_FIVE_EN
    end else if (remaining_i >= DENOM_5) begin
      coin_o = DENOM_5;
`endif
    end else if (remaining_i >= DENOM_2) begin
      coin_o = DENOM_2;
    end else if (remaining_i >= DENOM_1) begin
      coin_o = DENOM_1;
    end
  end

endmodule

// File: rtl/change_dispenser_controller.sv
// Pays out change (or a full refund) one coin at a time with a ready/ack handshake to the coin ejector.
// Denomination set is {10,2,1}, or {10,5,2,1} when DENOM_FIVE_EN is defined.
module change_dispenser_controller
  import change_dispenser_controller_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         refundAll,
  input  logic [4:0]   inputMoney,
  input  logic [4:0]   valueToPay,
  input  logic         dispenseAck,
  output logic         coinValid,
  output logic [4:0]   coinValue,
  output logic         noMoneyLeft,
  output logic         busy,
  output logic [4:0]   remaining,
  output logic [3:0]   coinCount
);

  logic [1:0]         state_q, state_d;
  logic [MONEY_W-1:0] remaining_q, remaining_d;
  logic               coin_valid_q, coin_valid_d;
  logic [MONEY_W-1:0] coin_value_q, coin_value_d;
  logic [COUNT_W-1:0] coin_count_q, coin_count_d;
  logic [MONEY_W-1:0] sel_coin;

  coin_selector u_coin_selector (
    .remaining_i (remaining_q),
    .coin_o      (sel_coin)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_valid_d = coin_valid_q;
    coin_value_d = coin_value_q;
    coin_count_d = coin_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d  = payout_amount(inputMoney, valueToPay, refundAll);
          coin_count_d = '0;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else begin
          coin_valid_d = 1'b1;
          coin_value_d = sel_coin;
          state_d      = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        // The offered coin never exceeds remaining, so this subtraction cannot wrap.
        if (dispenseAck && coin_valid_q) begin
          remaining_d  = remaining_q - coin_value_q;
          coin_valid_d = 1'b0;
          state_d      = ST_CALC;
          if (coin_count_q != {COUNT_W{1'b1}}) begin
            coin_count_d = coin_count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      coin_valid_q <= 1'b0;
      coin_value_q <= '0;
      coin_count_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      coin_value_q <= coin_value_d;
      coin_count_q <= coin_count_d;
    end
  end

  assign coinValid   = coin_valid_q;
  assign coinValue   = coin_value_q;
  assign remaining   = remaining_q;
  assign coinCount   = coin_count_q;
  assign noMoneyLeft = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_change_dispenser_controller.sv
// Randomized bench for change_dispenser_controller against a transaction-level payout model.
// Build with or without DENOM_FIVE_EN; expectations follow the same macro.
module tb_change_dispenser_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       refundAll = 1'b0;
  logic [4:0] inputMoney = '0;
  logic [4:0] valueToPay = '0;
  logic       dispenseAck = 1'b0;
  logic       coinValid;
  logic [4:0] coinValue;
  logic       noMoneyLeft;
  logic       busy;
  logic [4:0] remaining;
  logic [3:0] coinCount;

  change_dispenser_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .refundAll   (refundAll),
    .inputMoney  (inputMoney),
    .valueToPay  (valueToPay),
    .dispenseAck (dispenseAck),
    .coinValid   (coinValid),
    .coinValue   (coinValue),
    .noMoneyLeft (noMoneyLeft),
    .busy        (busy),
    .remaining   (remaining),
    .coinCount   (coinCount)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Greedy choice of the biggest coin that fits; the set depends on the build.
  function automatic int largest_coin(input int amt);
    if (amt >= 10) return 10;
`ifdef DENOM_FIVE_EN
    if (amt >= 5) return 5;
`endif
    if (amt >= 2) return 2;
    if (amt >= 1) return 1;
    return 0;
  endfunction

  // Model: a payout is a list of coins worked out up front; the controller then spends one
  // "thinking" cycle before each offer, holds each offer until acked, and ends with a done pulse.
  bit m_active = 0, m_done = 0, m_offer = 0;
  int m_rem = 0, m_cnt = 0;
  int m_coins[$];

  initial begin
    int amt, r, c;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_active = 0; m_done = 0; m_offer = 0; m_rem = 0; m_cnt = 0;
        m_coins.delete();
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          amt = (refundAll || (inputMoney < valueToPay)) ? int'(inputMoney)
                                                        : int'(inputMoney) - int'(valueToPay);
          m_rem = amt;
          m_cnt = 0;
          m_coins.delete();
          r = amt;
          while (r > 0) begin
            c = largest_coin(r);
            m_coins.push_back(c);
            r -= c;
          end
          m_active = 1;
          m_offer  = 0;
        end
      end else if (m_offer) begin
        if (dispenseAck) begin
          m_rem -= m_coins[0];
          void'(m_coins.pop_front());
          m_cnt  = (m_cnt < 15) ? m_cnt + 1 : 15;
          m_offer = 0;
        end
      end else if (m_coins.size() == 0) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_offer = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("busy", busy, (m_active || m_done) ? 1 : 0);
        check("noMoneyLeft", noMoneyLeft, m_done ? 1 : 0);
        check("coinValid", coinValid, m_offer ? 1 : 0);
        check("remaining", remaining, m_rem);
        check("coinCount", coinCount, m_cnt);
        if (m_offer) check("coinValue", coinValue, m_coins[0]);
      end
    end
  end

  int rec_q[$];
  int done_cyc, last_count, n_valid_cyc;

  // Runs one payout. dly<0 ties ack high; otherwise ack comes dly cycles after an offer appears.
  task automatic run_payout(input int money, input int price, input bit refund, input int dly,
                            input bit noise, input bit busy_start);
    int cyc, wcnt;
    bit seen;
    rec_q.delete();
    n_valid_cyc = 0; seen = 0; wcnt = 0; done_cyc = -1; last_count = -1;
    inputMoney = money[4:0];
    valueToPay = price[4:0];
    refundAll  = refund;
    start = 1'b1;
    dispenseAck = (dly < 0);
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (!seen && cyc < 200) begin
      if (noMoneyLeft) begin
        seen = 1;
        done_cyc = cyc;
        last_count = coinCount;
      end else begin
        if (dly < 0) begin
          dispenseAck = 1'b1;
        end else if (coinValid) begin
          dispenseAck = (wcnt >= dly);
          wcnt++;
        end else begin
          wcnt = 0;
          dispenseAck = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (coinValid) begin
          n_valid_cyc++;
          if (dispenseAck) rec_q.push_back(int'(coinValue));
        end
        if (busy_start) begin
          start      = 1'($urandom_range(0, 1));
          inputMoney = 5'($urandom_range(0, 31));
          refundAll  = 1'($urandom_range(0, 1));
        end
        @(posedge clock); #1;
        cyc++;
      end
    end
    if (!seen) check("payout_timeout", 0, 1);
    start = 1'b0;
    dispenseAck = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_coins(input string name, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_ncoins"}, rec_q.size(), n);
    for (int i = 0; i < n && i < rec_q.size(); i++) check({name, "_coin"}, rec_q[i], e[i]);
  endtask

  initial begin
    int money, price, dly, gap;
    bit refund;
    #3 reset = 1'b0;
    #1;
    check("rst_coinValid", coinValid, 0);
    check("rst_coinValue", coinValue, 0);
    check("rst_busy", busy, 0);
    check("rst_noMoneyLeft", noMoneyLeft, 0);
    check("rst_remaining", remaining, 0);
    check("rst_coinCount", coinCount, 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // 28 paid with price 2, ejector always ready.
    run_payout(28, 2, 1'b0, -1, 1'b0, 1'b0);
`ifdef DENOM_FIVE_EN
    check_coins("change26", 4, 10, 10, 5, 1, 0);
    check("change26_count", last_count, 4);
`else
    check_coins("change26", 5, 10, 10, 2, 2, 2);
    check("change26_count", last_count, 5);
`endif

    // Underpayment becomes a full refund.
    run_payout(7, 9, 1'b0, 0, 1'b0, 1'b0);
`ifdef DENOM_FIVE_EN
    check_coins("underpay7", 2, 5, 2, 0, 0, 0);
`else
    check_coins("underpay7", 4, 2, 2, 2, 1, 0);
`endif

    // Exact payment: no coins, done pulse in the second cycle after start.
    run_payout(5, 5, 1'b0, 0, 1'b1, 1'b0);
    check("exact_valid_cycles", n_valid_cyc, 0);
    check("exact_done_cycle", done_cyc, 2);

    // Slow ejector plus start pulses while busy.
    run_payout(28, 2, 1'b0, 3, 1'b1, 1'b1);
`ifdef DENOM_FIVE_EN
    check_coins("slowack", 4, 10, 10, 5, 1, 0);
    check("slowack_valid_cycles", n_valid_cyc, 16);
`else
    check_coins("slowack", 5, 10, 10, 2, 2, 2);
    check("slowack_valid_cycles", n_valid_cyc, 20);
`endif

    // Explicit refund of everything.
    run_payout(31, 4, 1'b1, 1, 1'b1, 1'b0);
    check_coins("refund31", 4, 10, 10, 10, 1, 0);

    // Reset while a 10-euro coin is on offer.
    inputMoney = 5'd20; valueToPay = 5'd0; refundAll = 1'b1; dispenseAck = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 10 && !coinValid; i++) begin
      @(posedge clock); #1;
    end
    check("abort_offer_valid", coinValid, 1);
    check("abort_offer_value", coinValue, 10);
    #1 reset = 1'b0;
    #1;
    check("abort_coinValid", coinValid, 0);
    check("abort_busy", busy, 0);
    check("abort_remaining", remaining, 0);
    check("abort_noMoneyLeft", noMoneyLeft, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    run_payout(3, 0, 1'b0, 0, 1'b0, 1'b0);
    check_coins("after_abort", 2, 2, 1, 0, 0, 0);
    check("after_abort_count", last_count, 2);

    // Randomized payouts.
    for (int t = 0; t < 40; t++) begin
      money  = $urandom_range(0, 31);
      price  = $urandom_range(0, 31);
      refund = 1'($urandom_range(0, 1));
      dly    = int'($urandom_range(0, 4)) - 1;
      run_payout(money, price, refund, dly, 1'b1, 1'b1);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clock); #1;
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t: got running, expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/change_dispenser_controller.md
CHANGE_DISPENSER_CONTROLLER -- requirements
Module: change_dispenser_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port start, input, 1 bit: one-cycle request from the main payment state machine to begin a payout.
REQ-004 SHALL have port refundAll, input, 1 bit: 1 = return all of inputMoney (invalid payment); 0 = return change.
REQ-005 SHALL have port inputMoney, input, 5 bits: euros inserted, unsigned.
REQ-006 SHALL have port valueToPay, input, 5 bits: price, unsigned.
REQ-007 SHALL have port dispenseAck, input, 1 bit: coin ejector has released the offered coin.
REQ-008 SHALL have port coinValid, output, 1 bit: a coin is being offered to the ejector.
REQ-009 SHALL have port coinValue, output, 5 bits: denomination offered, in euros.
REQ-010 SHALL have port noMoneyLeft, output, 1 bit: payout finished (one-cycle pulse).
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port remaining, output, 5 bits: euros still to be paid out.
REQ-013 SHALL have port coinCount, output, 4 bits: coins dispensed in the current payout, saturating at 15.

Function
REQ-014 SHALL implement states IDLE, CALC, DISPENSE and DONE.
REQ-015 IDLE with start=1 SHALL load remaining and move to CALC on the next edge.
- refundAll=1: load inputMoney.
- refundAll=0: load inputMoney-valueToPay.
- refundAll=0 and inputMoney<valueToPay: load inputMoney (full refund; no underflow).
REQ-016 IDLE with start=1 SHALL also clear coinCount to 0.
REQ-017 CALC with remaining=0 SHALL move to DONE.
REQ-018 CALC with remaining>0 SHALL move to DISPENSE, registering coinValid=1 and coinValue = largest enabled denomination <= remaining.
REQ-019 SHALL use the denomination set {10,5,2,1}, or {10,2,1} per REQ-030.
REQ-020 DISPENSE SHALL hold coinValid and coinValue stable until dispenseAck=1 is sampled; there is no timeout.
REQ-021 DISPENSE with dispenseAck=1 SHALL, on that edge:
- subtract coinValue from remaining;
- increment coinCount (saturating);
- clear coinValid;
- return to CALC.
REQ-022 SHALL ignore dispenseAck whenever coinValid=0.
REQ-023 DONE SHALL assert noMoneyLeft for exactly one cycle, then return to IDLE.
REQ-024 SHALL ignore start in every state except IDLE.
REQ-025 SHALL dispense each coin in at least 2 cycles (CALC plus at least one DISPENSE cycle).
REQ-026 remaining SHALL never wrap; coinValue <= remaining holds by construction.
REQ-027 All outputs SHALL be registered, or decoded directly from the state register.

Reset
REQ-028 reset=0 SHALL asynchronously force all of:
- state=IDLE;
- coinValid=0, coinValue=0;
- noMoneyLeft=0, busy=0;
- remaining=0, coinCount=0.
REQ-029 Reset mid-payout SHALL abandon the payout with no noMoneyLeft pulse; coinValid falls asynchronously.

Configuration
REQ-030 Macro DENOM_FIVE_EN SHALL control the 5-euro coin:
- defined: 5-euro coin in the denomination set;
- undefined: set is {10,2,1} and coinValue never equals 5.

Structure
REQ-031 A shared package SHALL hold:
- state encoding (2 bits);
- denomination constants;
- money width (5).
REQ-032 A combinational sub-module coin_selector SHALL map remaining to the largest enabled denomination.

Verification
REQ-033 DENOM_FIVE_EN defined; inputMoney=28, valueToPay=2, refundAll=0, dispenseAck tied 1 -> coins 10,10,5,1; remaining 26,16,6,1,0; coinCount=4; noMoneyLeft one pulse.
REQ-034 DENOM_FIVE_EN undefined; same stimulus as REQ-033 -> coins 10,10,2,2,2; coinCount=5.
REQ-035 inputMoney=7, valueToPay=9, refundAll=0 -> full refund, coins 5,2 (or 2,2,2,1 without the macro).
REQ-036 inputMoney=5, valueToPay=5 -> coinValid never high; noMoneyLeft high exactly in the 2nd cycle after start is sampled.
REQ-037 dispenseAck delayed 3 cycles per coin -> coinValid and coinValue held steady throughout; no double decrement; start pulsed while busy has no effect.
REQ-038 reset asserted during DISPENSE of a 10-euro coin -> coinValid=0 immediately; state IDLE; no noMoneyLeft pulse; next start works normally.
